// File: rtl/inference_reader.sv
// Inference reader: streams words out of a dual-port inference memory into a 2-entry skid FIFO.
// Define INFERENCE_READER_OVF_EN to drop the oldest entry and flag overflow when the writer laps.
module inference_reader #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic              mem_re_b,
    output logic              mem_we_b,
    output logic [DATA_W-1:0] mem_din_b,
    input  logic [DATA_W-1:0] mem_dout_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_tag,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_fl_tag;
    logic [DATA_W-1:0] r_buf_data [2];
    logic [ADDR_W-1:0] r_buf_tag  [2];
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_occ;

    logic              w_pop;
    logic [1:0]        w_load;
    logic              w_issue;
    logic              w_ovf_evt;
    logic              w_adv;

    // Occupancy seen after this cycle's pop, so a draining buffer keeps one read per cycle.
    assign w_pop     = (r_occ != 2'd0) && out_ready;
    assign w_load    = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue   = (r_count != '0) && (w_load < 2'd2);
    assign w_ovf_evt = wr_en && (r_count == L_DEPTH) && !w_issue;

`ifdef INFERENCE_READER_OVF_EN
    assign w_adv = w_issue || w_ovf_evt;
`else
    assign w_adv = w_issue;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_fl_tag   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fl_tag <= r_rd_ptr;
            end
            if (w_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (wr_en && !w_issue && !w_ovf_evt) begin
                r_count <= r_count + 1'b1;
            end else if (!wr_en && w_issue) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_tag[0]  <= '0;
            r_buf_tag[1]  <= '0;
            r_wp          <= 1'b0;
            r_rp          <= 1'b0;
            r_occ         <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_buf_data[r_wp] <= mem_dout_b;
                r_buf_tag[r_wp]  <= r_fl_tag;
                r_wp             <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

`ifdef INFERENCE_READER_OVF_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign mem_addr_b = r_rd_ptr;
    assign mem_re_b   = w_issue;
    assign mem_we_b   = 1'b0;
    assign mem_din_b  = '0;
    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = out_valid ? r_buf_data[r_rp] : '0;
    assign out_tag    = out_valid ? r_buf_tag[r_rp] : '0;
    assign count      = r_count;

endmodule

// File: tb/tb_inference_reader.sv
// Directed bench for inference_reader with a registered port-B memory model.
// Expectations follow INFERENCE_READER_OVF_EN when it is defined.
module tb_inference_reader;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [1:0] mem_addr_b;
    logic       mem_re_b;
    logic       mem_we_b;
    logic [3:0] mem_din_b;
    logic [3:0] mem_dout_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_tag;
    logic [2:0] count;
    logic       overflow;

    logic [3:0] mem [4];
    int         n_checks;
    int         n_fail;
    int         n_reads;
    int         base;
    logic [3:0] q_data [$];
    logic [1:0] q_tag  [$];

    inference_reader #(.DATA_W(4), .ADDR_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .mem_addr_b (mem_addr_b),
        .mem_re_b   (mem_re_b),
        .mem_we_b   (mem_we_b),
        .mem_din_b  (mem_din_b),
        .mem_dout_b (mem_dout_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .count      (count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re_b) mem_dout_b <= mem[mem_addr_b];
    end

    always @(negedge clk) begin
        if (reset_n && mem_re_b) n_reads++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_tag [3];
        n_checks   = 0;
        n_fail     = 0;
        n_reads    = 0;
        mem_dout_b = '0;
        for (int i = 0; i < 4; i++) mem[i] = '0;

        // Reset state
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_re", mem_re_b, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", out_data, 0);
        check("rst_tag", out_tag, 0);
        check("rst_addr", mem_addr_b, 0);
        check("we_b", mem_we_b, 0);
        check("din_b", mem_din_b, 0);
        reset_n = 1'b1;

        // Single word latency
        mem[0] = 4'hA;
        tick();
        wr_en = 1'b1;
        #1;
        check("empty_re", mem_re_b, 0);
        tick();
        wr_en = 1'b0;
        #1;
        check("c1_re", mem_re_b, 1);
        check("c1_addr", mem_addr_b, 0);
        tick();
        check("c2_valid", out_valid, 0);
        check("c2_re", mem_re_b, 0);
        tick();
        check("c3_valid", out_valid, 1);
        check("c3_data", out_data, 4'hA);
        check("c3_tag", out_tag, 0);
        out_ready = 1'b1;
        tick();
        check("c4_valid", out_valid, 0);

        // Streaming at full rate
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 4'(i + 1);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            wr_en = (c < 4);
            #1;
            if (c >= 3 && c <= 6) begin
                check($sformatf("st_valid%0d", c), out_valid, 1);
                check($sformatf("st_data%0d", c), out_data, c - 2);
                check($sformatf("st_tag%0d", c), out_tag, c - 3);
            end
        end
        wr_en = 1'b0;
        tick();
        check("st_count", count, 0);
        check("st_valid_end", out_valid, 0);

        // Backpressure
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 4'(i + 5);
        base = n_reads;
        for (int c = 0; c < 10; c++) begin
            tick();
            wr_en = (c < 4);
            #1;
        end
        wr_en = 1'b0;
        check("bp_reads", n_reads - base, 2);
        check("bp_count", count, 2);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 5);
        check("bp_re", mem_re_b, 0);
        tick();
        check("bp_hold", out_data, 5);
        out_ready = 1'b1;
        #1;
        q_data.delete();
        for (int i = 0; i < 20; i++) begin
            if (out_valid) q_data.push_back(out_data);
            tick();
        end
        check("bp_ndel", q_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_data.size())
                check($sformatf("bp_word%0d", i), q_data[i], i + 5);
        end
        check("bp_reads_all", n_reads - base, 4);
        check("bp_count_end", count, 0);

        // Wrap and overflow
        do_reset();
        for (int c = 0; c < 7; c++) begin
            tick();
            wr_en = 1'b1;
            #1;
        end
        tick();
        wr_en = 1'b0;
        #1;
        check("ov_count", count, 4);
`ifdef INFERENCE_READER_OVF_EN
        check("ov_flag", overflow, 1);
        exp_tag[0] = 2'd0;
        exp_tag[1] = 2'd1;
        exp_tag[2] = 2'd3;
`else
        check("ov_flag", overflow, 0);
        exp_tag[0] = 2'd0;
        exp_tag[1] = 2'd1;
        exp_tag[2] = 2'd2;
`endif
        out_ready = 1'b1;
        #1;
        q_tag.delete();
        for (int i = 0; i < 20; i++) begin
            if (out_valid) q_tag.push_back(out_tag);
            tick();
        end
        check("ov_ndel_min3", q_tag.size() >= 3, 1);
        for (int i = 0; i < 3; i++) begin
            if (i < q_tag.size())
                check($sformatf("ov_tag%0d", i), q_tag[i], exp_tag[i]);
        end
`ifdef INFERENCE_READER_OVF_EN
        check("ov_sticky", overflow, 1);
`else
        check("ov_sticky", overflow, 0);
`endif

        // Reset mid-operation
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            wr_en = 1'b1;
            #1;
        end
        tick();
        wr_en = 1'b0;
        #1;
        check("mr_pre_count", count, 3);
        check("mr_pre_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mr_valid", out_valid, 0);
        check("mr_count", count, 0);
        check("mr_re", mem_re_b, 0);
        tick();
        reset_n = 1'b1;
        tick();
        wr_en = 1'b1;
        #1;
        tick();
        wr_en = 1'b0;
        #1;
        check("mr_re_after", mem_re_b, 1);
        check("mr_addr_after", mem_addr_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
